alu_serial_rx: RTL and testbench



---
 rtl/alu_serial_rx_if.sv | 28 ++
 rtl/alu_serial_rx.sv | 117 +++++++++++
 tb/tb_alu_serial_rx.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_serial_rx_if.sv
// rtl/alu_serial_rx_if.sv - serial line in, decoded ALU command out
`timescale 1ns/1ps
interface alu_serial_rx_if;
    logic        sin;
    logic        cmd_valid;
    logic [31:0] a_out;
    logic [31:0] b_out;
    logic [2:0]  op_out;
    logic [3:0]  crc4_out;
    logic        crc_ok;
    logic        op_ok;
    logic        err_data;
    logic        err_frame;

    // Receiver side: consumes the serial line, produces the command.
    modport master (
        input  sin,
        output cmd_valid, a_out, b_out, op_out, crc4_out,
        output crc_ok, op_ok, err_data, err_frame
    );

    // Driver/consumer side: drives the serial line, reads the command.
    modport slave (
        output sin,
        input  cmd_valid, a_out, b_out, op_out, crc4_out,
        input  crc_ok, op_ok, err_data, err_frame
    );
endinterface

// File: rtl/alu_serial_rx.sv
// rtl/alu_serial_rx.sv - deframes 11-bit serial packets into ALU commands with CRC-4 check
`timescale 1ns/1ps
module alu_serial_rx #(
    parameter logic [3:0] CRC_INIT    = 4'b0000,
    parameter int         DATA_FRAMES = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_serial_rx_if.master bus
);
    localparam int             CW         = $clog2(DATA_FRAMES + 1);
    localparam int             DW         = 8 * DATA_FRAMES;
    localparam logic [CW-1:0]  LAST_FRAME = CW'(DATA_FRAMES);

    typedef enum logic [1:0] {IDLE, TYPE, BITS, STOP} state_t;

    state_t          state;
    logic            is_ctl;
    logic [2:0]      bit_cnt;
    logic [CW-1:0]   frame_cnt;
    logic [7:0]      byte_sr;
    logic [DW-1:0]   data_sr;
    logic [3:0]      crc;
    logic [3:0]      crc_final;
    logic            op_legal;

    // One step of the x^4+x+1 serial LFSR.
    function automatic logic [3:0] crc_step(input logic [3:0] c, input logic b);
        logic fb;
        fb = b ^ c[3];
        return {c[2], c[1], c[0] ^ fb, fb};
    endfunction

    // Fold the trailing {1, op} bits into the running CRC for the CTL stop check.
    always_comb begin
        crc_final = crc_step(crc_step(crc_step(crc_step(crc, 1'b1),
                        byte_sr[6]), byte_sr[5]), byte_sr[4]);
    end

    // Legal opcodes are AND, OR, ADD, SUB with the reserved payload bit clear.
    always_comb begin
        op_legal = 1'b0;
        case (byte_sr[6:4])
            3'b000, 3'b001, 3'b100, 3'b101: op_legal = ~byte_sr[7];
            default:                        op_legal = 1'b0;
        endcase
    end

    // Packet FSM, message assembly, CRC accumulation and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            is_ctl        <= 1'b0;
            bit_cnt       <= '0;
            frame_cnt     <= '0;
            byte_sr       <= '0;
            data_sr       <= '0;
            crc           <= CRC_INIT;
            bus.cmd_valid <= 1'b0;
            bus.err_data  <= 1'b0;
            bus.err_frame <= 1'b0;
            bus.a_out     <= '0;
            bus.b_out     <= '0;
            bus.op_out    <= '0;
            bus.crc4_out  <= '0;
            bus.crc_ok    <= 1'b0;
            bus.op_ok     <= 1'b0;
        end else begin
            bus.cmd_valid <= 1'b0;
            bus.err_data  <= 1'b0;
            bus.err_frame <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.sin) state <= TYPE;
                end
                TYPE: begin
                    is_ctl  <= bus.sin;
                    bit_cnt <= '0;
                    state   <= BITS;
                end
                BITS: begin
                    byte_sr <= {byte_sr[6:0], bus.sin};
                    if (!is_ctl) crc <= crc_step(crc, bus.sin);
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state <= STOP;
                end
                STOP: begin
                    state <= IDLE;
                    if (!bus.sin || is_ctl || frame_cnt == LAST_FRAME) begin
                        // Every outcome except an accepted DATA packet ends the message.
                        frame_cnt <= '0;
                        crc       <= CRC_INIT;
                        data_sr   <= '0;
                        byte_sr   <= '0;
                        if (!bus.sin) begin
                            bus.err_frame <= 1'b1;
                        end else if (is_ctl && frame_cnt == LAST_FRAME) begin
                            bus.cmd_valid <= 1'b1;
                            bus.b_out     <= data_sr[DW-1 -: 32];
                            bus.a_out     <= data_sr[31:0];
                            bus.op_out    <= byte_sr[6:4];
                            bus.crc4_out  <= byte_sr[3:0];
                            bus.crc_ok    <= (crc_final == byte_sr[3:0]);
                            bus.op_ok     <= op_legal;
                        end else begin
                            bus.err_data <= 1'b1;
                        end
                    end else begin
                        data_sr   <= {data_sr[DW-9:0], byte_sr};
                        frame_cnt <= frame_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_serial_rx.sv
// tb/tb_alu_serial_rx.sv - directed scoreboard bench for alu_serial_rx
`timescale 1ns/1ps
module tb_alu_serial_rx;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_serial_rx_if bus();

    alu_serial_rx dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    localparam logic [2:0] K_CMD  = 3'b100;
    localparam logic [2:0] K_EDAT = 3'b010;
    localparam logic [2:0] K_EFRM = 3'b001;

    typedef struct {
        logic [2:0]  kind;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  op;
        logic [3:0]  crc4;
        logic        crc_ok;
        logic        op_ok;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [31:0] held_a = '0, held_b = '0;
    logic [2:0]  held_op = '0;
    logic [3:0]  held_crc4 = '0;
    logic        held_crc_ok = 1'b0, held_op_ok = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_crc(input logic [63:0] ba, input logic [2:0] op);
        logic [67:0] s;
        logic [3:0]  c;
        logic        fb;
        s = {ba, 1'b1, op};
        c = 4'b0000;
        for (int i = 67; i >= 0; i--) begin
            fb = s[i] ^ c[3];
            c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
        end
        return c;
    endfunction

    // Scoreboard consumer: every pulse must match the oldest expectation.
    always @(negedge clk) begin
        logic [2:0] pulses;
        exp_t e;
        pulses = {bus.cmd_valid, bus.err_data, bus.err_frame};
        if (pulses != 3'b000) begin
            if (sb.size() == 0) begin
                check("spurious_pulse", 64'(pulses), 64'd0);
            end else begin
                e = sb.pop_front();
                check("pulse_kind", 64'(pulses), 64'(e.kind));
                check("pulse_cycle", 64'(cyc), 64'(e.cyc));
                check("a_out", 64'(bus.a_out), 64'(e.a));
                check("b_out", 64'(bus.b_out), 64'(e.b));
                check("op_out", 64'(bus.op_out), 64'(e.op));
                check("crc4_out", 64'(bus.crc4_out), 64'(e.crc4));
                check("crc_ok", 64'(bus.crc_ok), 64'(e.crc_ok));
                check("op_ok", 64'(bus.op_ok), 64'(e.op_ok));
            end
        end
    end

    task automatic send_packet(input logic typ, input logic [7:0] d, input logic stop);
        logic [10:0] f;
        f = {1'b0, typ, d, stop};
        for (int i = 10; i >= 0; i--) begin
            @(negedge clk);
            bus.sin = f[i];
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            bus.sin = 1'b1;
        end
    endtask

    task automatic push_err(input logic [2:0] kind);
        exp_t e;
        e = '{kind: kind, a: held_a, b: held_b, op: held_op, crc4: held_crc4,
              crc_ok: held_crc_ok, op_ok: held_op_ok, cyc: cyc + 1};
        sb.push_back(e);
    endtask

    task automatic send_msg(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                            input logic [3:0] crc_flip, input logic bit7);
        logic [63:0] ba;
        logic [3:0]  crc;
        exp_t e;
        ba  = {b, a};
        crc = model_crc(ba, op) ^ crc_flip;
        for (int i = 0; i < 8; i++) send_packet(1'b0, ba[63 - 8*i -: 8], 1'b1);
        send_packet(1'b1, {bit7, op, crc}, 1'b1);
        held_a      = a;
        held_b      = b;
        held_op     = op;
        held_crc4   = crc;
        held_crc_ok = (crc_flip == 4'b0000);
        held_op_ok  = !bit7 && (op == 3'b000 || op == 3'b001 || op == 3'b100 || op == 3'b101);
        e = '{kind: K_CMD, a: held_a, b: held_b, op: held_op, crc4: held_crc4,
              crc_ok: held_crc_ok, op_ok: held_op_ok, cyc: cyc + 1};
        sb.push_back(e);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_pulses"}, 64'({bus.cmd_valid, bus.err_data, bus.err_frame}), 64'd0);
        check({tag, "_a"}, 64'(bus.a_out), 64'd0);
        check({tag, "_b"}, 64'(bus.b_out), 64'd0);
        check({tag, "_op"}, 64'(bus.op_out), 64'd0);
        check({tag, "_crc4"}, 64'(bus.crc4_out), 64'd0);
        check({tag, "_oks"}, 64'({bus.crc_ok, bus.op_ok}), 64'd0);
    endtask

    initial begin
        logic [10:0] f;
        bus.sin = 1'b1;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        idle(20);

        // Basic ADD message and a corrupted-CRC copy.
        send_msg(32'h0000_0003, 32'h0000_0005, 3'b100, 4'b0000, 1'b0);
        idle(4);
        send_msg(32'h0000_0003, 32'h0000_0005, 3'b100, 4'b0001, 1'b0);
        idle(4);

        // Short message: 7 DATA then CTL.
        for (int i = 0; i < 7; i++) send_packet(1'b0, 8'(8'h11 * i), 1'b1);
        send_packet(1'b1, 8'h40, 1'b1);
        push_err(K_EDAT);
        idle(3);
        send_msg(32'hFFFF_FFFF, 32'h8000_0000, 3'b000, 4'b0000, 1'b0);
        idle(2);

        // Framing error on the third packet, then a good back-to-back message.
        send_packet(1'b0, 8'hAA, 1'b1);
        send_packet(1'b0, 8'h55, 1'b1);
        send_packet(1'b0, 8'hC3, 1'b0);
        push_err(K_EFRM);
        idle(3);
        send_msg($urandom, $urandom, 3'b101, 4'b0000, 1'b0);
        send_msg($urandom, $urandom, 3'b001, 4'b0000, 1'b0);
        idle(2);

        // Illegal opcode, and a legal opcode with the reserved bit set.
        send_msg(32'h1234_5678, 32'h9ABC_DEF0, 3'b011, 4'b0000, 1'b0);
        idle(2);
        send_msg(32'h0F0F_0F0F, 32'hF0F0_F0F0, 3'b100, 4'b0000, 1'b1);
        idle(2);

        // Ninth DATA packet where CTL is expected.
        for (int i = 0; i < 9; i++) send_packet(1'b0, 8'(8'h21 + i), 1'b1);
        push_err(K_EDAT);
        idle(3);
        send_msg(32'hDEAD_BEEF, 32'h0000_0001, 3'b101, 4'b0000, 1'b0);
        idle(2);

        // Reset in the middle of the fifth DATA packet.
        for (int i = 0; i < 4; i++) send_packet(1'b0, 8'h3C, 1'b1);
        f = {1'b0, 1'b0, 8'hA5, 1'b1};
        for (int i = 10; i >= 5; i--) begin
            @(negedge clk);
            bus.sin = f[i];
        end
        @(negedge clk);
        rst_n = 1'b0;
        bus.sin = 1'b1;
        #1;
        check_zero_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        held_a = '0; held_b = '0; held_op = '0; held_crc4 = '0;
        held_crc_ok = 1'b0; held_op_ok = 1'b0;
        idle(5);
        send_msg(32'hCAFE_F00D, 32'h0BAD_0BAD, 3'b100, 4'b0000, 1'b0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        idle(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
